// File: rtl/sar_defs.sv
// Shared definitions for the successive-approximation value finder.
// State encoding for the search FSM and a helper that checks whether the
// comparator flag triple is one-hot (exactly one of equal/greater/lower high).
package sar_defs;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // True when exactly one comparator flag is asserted.
  function automatic logic flags_onehot(input logic eq, input logic gt, input logic lt);
    return ({eq, gt, lt} == 3'b100) || ({eq, gt, lt} == 3'b010) || ({eq, gt, lt} == 3'b001);
  endfunction

endpackage

// File: rtl/sar_value_finder.sv
// Purpose: binary-search master driving comparator operand B to locate the value on operand A.
// Latency: done pulses N cycles after the start edge, N = probes used (1..WIDTH+1).
// Backpressure: none; start is only sampled in IDLE, ignored while busy or during the done cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    request a new search (IDLE only)
//   equal, greater, lower    comparator flags for the current probe
//   probe                    registered value driven to comparator operand B
//   busy                     high while searching
//   done                     one-cycle completion pulse
//   found, err, result       outcome of the last search, held until next start
//   n_probes                 probes used by the last search, held until next start
module sar_value_finder
  import sar_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             equal,
  input  logic             greater,
  input  logic             lower,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH:0]   n_probes
);

  localparam logic [WIDTH:0]   ONE   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   MAXV  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   LIMIT = (WIDTH + 1)'(WIDTH + 1);
  localparam logic [WIDTH-1:0] FIRST = {1'b0, {(WIDTH-1){1'b1}}};

  state_t state_q, state_d;

  // lo/hi carry one extra bit: lo may reach 2^WIDTH and hi may reach -1
  // (all ones) without wrapping into the valid range.
  logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d, cnt_q, cnt_d;
  logic [WIDTH-1:0] probe_d, result_d;
  logic [WIDTH:0]   n_probes_d;
  logic             done_d, found_d, err_d;
  logic [WIDTH+1:0] sum;

  assign busy = (state_q == S_SEARCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      probe    <= '0;
      done     <= 1'b0;
      found    <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      n_probes <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      probe    <= probe_d;
      done     <= done_d;
      found    <= found_d;
      err      <= err_d;
      result   <= result_d;
      n_probes <= n_probes_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    probe_d    = probe;
    done_d     = 1'b0;
    found_d    = found;
    err_d      = err;
    result_d   = result;
    n_probes_d = n_probes;
    sum        = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = MAXV;
          probe_d  = FIRST;
          cnt_d    = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = S_SEARCH;
        end
      end

      S_SEARCH: begin
        cnt_d = cnt_q + ONE;
        if (!flags_onehot(equal, greater, lower)) begin
          // Broken comparator: probe stays where it was.
          err_d = 1'b1;
        end else if (equal) begin
          result_d = probe;
          found_d  = 1'b1;
        end else begin
          if (greater) lo_d = {1'b0, probe} + ONE;
          if (lower)   hi_d = {1'b0, probe} - ONE;
          // lo is never negative, hi is never above 2^WIDTH-1, so a one-bit
          // sign extension of hi is enough for a signed window check.
          if ($signed({1'b0, lo_d}) > $signed({hi_d[WIDTH], hi_d})) begin
            err_d = 1'b1;
          end else if (cnt_d == LIMIT) begin
            err_d = 1'b1;
          end else begin
            sum     = {1'b0, lo_d} + {1'b0, hi_d};
            probe_d = sum[WIDTH:1];
          end
        end
        if (err_d || found_d) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          n_probes_d = cnt_d;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_value_finder.sv
module tb_sar_value_finder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic         byp;
  logic         byp_eq, byp_gt, byp_lt;
  logic         equal, greater, lower;
  logic [W-1:0] probe;
  logic         busy, done, found, err;
  logic [W-1:0] result;
  logic [W:0]   n_probes;

  int nvec = 0;
  int nerr = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  // Combinational comparator on operand A = a, operand B = probe, with an
  // override path for injecting illegal flag patterns.
  assign equal   = byp ? byp_eq : (a == probe);
  assign greater = byp ? byp_gt : (a >  probe);
  assign lower   = byp ? byp_lt : (a <  probe);

  sar_value_finder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .equal    (equal),
    .greater  (greater),
    .lower    (lower),
    .probe    (probe),
    .busy     (busy),
    .done     (done),
    .found    (found),
    .err      (err),
    .result   (result),
    .n_probes (n_probes)
  );

  task automatic check(input int obs, input int expv, input string tag);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: textbook integer binary search over 0..2^W-1; returns the
  // sequence of midpoints tried until the target is hit.
  task automatic model(input int target);
    int lo, hi, m;
    exp_q.delete();
    lo = 0;
    hi = (1 << W) - 1;
    while (lo <= hi) begin
      m = (lo + hi) / 2;
      exp_q.push_back(m);
      if (m == target) break;
      if (target > m) lo = m + 1;
      else hi = m - 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete search with a correct comparator; checks each probe, the
  // latency, the final outputs and the single-cycle done pulse. Returns in
  // the cycle after done so the next call starts back-to-back.
  task automatic run_search(input int target, input string tag);
    int cyc;
    model(target);
    a     = W'(target);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 3 * W) begin
      check(32'(busy), 1, {tag, "_busy"});
      if (cyc < exp_q.size()) check(32'(probe), exp_q[cyc], {tag, "_probe"});
      tick();
      cyc++;
    end
    check(32'(done), 1, {tag, "_done_seen"});
    check(cyc, exp_q.size(), {tag, "_latency"});
    check(32'(found), 1, {tag, "_found"});
    check(32'(err), 0, {tag, "_err"});
    check(32'(result), target, {tag, "_result"});
    check(32'(n_probes), exp_q.size(), {tag, "_nprobes"});
    check(32'(n_probes <= 5'(W + 1)), 1, {tag, "_nprobes_max"});
    check(32'(busy), 0, {tag, "_busy_in_done"});
    tick();
    check(32'(done), 0, {tag, "_done_width"});
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    byp    = 1'b0;
    byp_eq = 1'b0;
    byp_gt = 1'b0;
    byp_lt = 1'b0;
    tick();
    tick();
    check(32'(probe), 0, "rst_probe");
    check(32'(busy), 0, "rst_busy");
    check(32'(done), 0, "rst_done");
    check(32'(found), 0, "rst_found");
    check(32'(err), 0, "rst_err");
    check(32'(result), 0, "rst_result");
    check(32'(n_probes), 0, "rst_nprobes");
    rst = 1'b0;
    tick();

    // Directed corners: first probe hit, lowest value, worst case.
    run_search(7, "a7");
    check(exp_q.size(), 1, "a7_len");
    run_search(0, "a0");
    check(exp_q.size(), 4, "a0_len");
    run_search(15, "a15");
    check(exp_q.size(), 5, "a15_len");

    // Every value, back-to-back.
    for (int v = 0; v < (1 << W); v++) run_search(v, "sweep");

    // Random targets.
    for (int i = 0; i < 20; i++) run_search(int'($urandom_range(0, (1 << W) - 1)), "rand");

    // Illegal flags (greater and lower together); start held high through
    // SEARCH and DONE must not restart the search.
    byp    = 1'b1;
    byp_gt = 1'b1;
    byp_lt = 1'b1;
    start  = 1'b1;
    tick();
    check(32'(busy), 1, "ill_busy");
    check(32'(probe), 7, "ill_probe");
    tick();
    check(32'(done), 1, "ill_done");
    check(32'(err), 1, "ill_err");
    check(32'(found), 0, "ill_found");
    check(32'(n_probes), 1, "ill_nprobes");
    check(32'(probe), 7, "ill_probe_held");
    tick();
    check(32'(busy), 0, "ill_start_ignored");
    check(32'(done), 0, "ill_done_width");
    check(32'(err), 1, "ill_err_held");
    start = 1'b0;
    tick();

    // No flag at all is also illegal.
    byp_gt = 1'b0;
    byp_lt = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check(32'(done), 1, "none_done");
    check(32'(err), 1, "none_err");
    check(32'(found), 0, "none_found");
    byp = 1'b0;
    tick();

    // Reset on the second SEARCH cycle abandons the search silently.
    a     = W'(15);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check(32'(busy), 1, "mid_busy");
    check(32'(probe), 11, "mid_probe");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check(32'(probe), 0, "mrst_probe");
    check(32'(busy), 0, "mrst_busy");
    check(32'(done), 0, "mrst_done");
    check(32'(found), 0, "mrst_found");
    check(32'(err), 0, "mrst_err");
    check(32'(result), 0, "mrst_result");
    check(32'(n_probes), 0, "mrst_nprobes");
    for (int i = 0; i < 6; i++) begin
      tick();
      check(32'(done), 0, "mrst_no_done");
      check(32'(busy), 0, "mrst_idle");
    end
    run_search(15, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
